// File: rtl/ddr_lane_sched.sv
// Round-robin scheduler that shares one dual-edge output lane between N requesters.
// state  | meaning
// IDLE   | no owner; choose the next requester round-robin
// XFER   | owner streams beats; a stall watchdog runs
// GAP    | turnaround idle cycles after each packet
module ddr_lane_sched #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           req_valid_i,
    input  logic [N*2*W-1:0]       req_data_i,
    input  logic [N-1:0]           req_last_i,
    output logic [N-1:0]           req_ready_o,
    output logic                   lane_en_o,
    output logic [W-1:0]           lane_rise_o,
    output logic [W-1:0]           lane_fall_o,
    output logic                   lane_sop_o,
    output logic                   lane_eop_o,
    output logic [$clog2(N)-1:0]   lane_owner_o,
    output logic                   abort_o,
    output logic                   busy_o
);
    localparam int OW     = $clog2(N);
    localparam int SW     = $clog2(TIMEOUT + 1);
    localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int GAP_LD = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;
    localparam state_t PKT_DONE = (GAP == 0) ? S_IDLE : S_GAP;

    state_t          state_q;
    logic [OW-1:0]   owner_q;
    logic [OW-1:0]   rr_ptr_q;
    logic [SW-1:0]   stall_q;
    logic [GW-1:0]   gap_q;
    logic            sop_pend_q;
    logic            lane_en_q;
    logic [W-1:0]    lane_rise_q;
    logic [W-1:0]    lane_fall_q;
    logic            lane_sop_q;
    logic            lane_eop_q;
    logic            abort_q;

    logic            beat;
    logic            beat_valid;
    logic            beat_last;
    logic [2*W-1:0]  beat_data;
    logic            grant_found;
    logic [OW-1:0]   grant_idx;
    logic [OW-1:0]   cand;

    always_comb begin
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        beat_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (owner_q == OW'(k)) begin
                beat_valid = req_valid_i[k];
                beat_last  = req_last_i[k];
                beat_data  = req_data_i[k*2*W +: 2*W];
            end
        end
        beat = (state_q == S_XFER) && beat_valid;
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = OW'((int'(rr_ptr_q) + k) % N);
            if (!grant_found && req_valid_i[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == S_XFER) begin
            req_ready_o[owner_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= OW'(N - 1);
            stall_q     <= '0;
            gap_q       <= '0;
            sop_pend_q  <= 1'b0;
            lane_en_q   <= 1'b0;
            lane_rise_q <= '0;
            lane_fall_q <= '0;
            lane_sop_q  <= 1'b0;
            lane_eop_q  <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            lane_en_q  <= 1'b0;
            lane_sop_q <= 1'b0;
            lane_eop_q <= 1'b0;
            abort_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found) begin
                        owner_q    <= grant_idx;
                        stall_q    <= '0;
                        sop_pend_q <= 1'b1;
                        state_q    <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        lane_en_q   <= 1'b1;
                        lane_rise_q <= beat_data[W-1:0];
                        lane_fall_q <= beat_data[2*W-1:W];
                        lane_sop_q  <= sop_pend_q;
                        sop_pend_q  <= 1'b0;
                        stall_q     <= '0;
                        if (beat_last) begin
                            lane_eop_q <= 1'b1;
                            rr_ptr_q   <= owner_q;
                            gap_q      <= GW'(GAP_LD);
                            state_q    <= PKT_DONE;
                        end
                    end else if (stall_q == SW'(TIMEOUT - 1)) begin
                        // Lane data is left as-is; only the abort pulse marks the truncation.
                        abort_q  <= 1'b1;
                        rr_ptr_q <= owner_q;
                        gap_q    <= GW'(GAP_LD);
                        state_q  <= PKT_DONE;
                    end else begin
                        stall_q <= stall_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign lane_en_o    = lane_en_q;
    assign lane_rise_o  = lane_rise_q;
    assign lane_fall_o  = lane_fall_q;
    assign lane_sop_o   = lane_sop_q;
    assign lane_eop_o   = lane_eop_q;
    assign lane_owner_o = owner_q;
    assign abort_o      = abort_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ddr_lane_sched.sv
// Scoreboard bench for ddr_lane_sched: drivers queue expected lane beats, a monitor checks them.
module tb_ddr_lane_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        lane_en;
    logic [7:0]  lane_rise;
    logic [7:0]  lane_fall;
    logic        lane_sop;
    logic        lane_eop;
    logic [1:0]  lane_owner;
    logic        abort_w;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int abort_cyc = 0;
    int n_abort = 0;

    logic [19:0] exp_q[$];
    int          abort_exp_q[$];
    int          eop_q[$];

    ddr_lane_sched #(.N(4), .W(8), .GAP(2), .TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .lane_en_o(lane_en), .lane_rise_o(lane_rise), .lane_fall_o(lane_fall),
        .lane_sop_o(lane_sop), .lane_eop_o(lane_eop), .lane_owner_o(lane_owner),
        .abort_o(abort_w), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every lane beat and abort pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("sop_eop_qual", {30'd0, {lane_sop, lane_eop} & {2{~lane_en}}}, 32'd0);
            if (lane_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lane_unexpected actual=%h required=none", {lane_owner, lane_rise, lane_fall, lane_sop, lane_eop});
                end else begin
                    chk("lane_beat", {12'd0, lane_owner, lane_rise, lane_fall, lane_sop, lane_eop}, {12'd0, exp_q.pop_front()});
                end
                if (lane_eop) eop_q.push_back(cyc);
            end
            if (abort_w) begin
                n_abort++;
                abort_cyc = cyc;
                if (abort_exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL abort_unexpected actual=1 required=0 owner=%0d", lane_owner);
                end else begin
                    chk("abort_owner", {30'd0, lane_owner}, abort_exp_q.pop_front());
                end
                chk("abort_no_eop", {31'd0, lane_eop}, 32'd0);
            end
        end
    end

    task automatic send_beat(input int r, input logic [15:0] d, input logic last, input logic sop);
        int  n;
        bit  ok;
        ok = 1'b0;
        req_valid[r] = 1'b1;
        req_data[r*16 +: 16] = d;
        req_last[r] = last;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (req_ready[r]) begin
                exp_q.push_back({r[1:0], d[7:0], d[15:8], sop, last});
                acc_cyc = cyc;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout actual=no_ready required=ready req=%0d", r);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {4'd0, req_ready, lane_en, lane_rise, lane_fall, lane_sop, lane_eop, lane_owner, abort_w, busy}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL sim_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [15:0] bp_data[4];
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          n0;

        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_init_outputs");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single requester, three back-to-back beats, then the 2-cycle gap.
        send_beat(1, 16'h1122, 1'b0, 1'b1);
        send_beat(1, 16'h3344, 1'b0, 1'b0);
        send_beat(1, 16'h5566, 1'b1, 1'b0);
        @(negedge clk);
        chk("gap_busy_1", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("gap_busy_2", {31'd0, busy}, 32'd1);
        chk("gap_ready_zero", {28'd0, req_ready}, 32'd0);
        chk("gap_lane_en_zero", {31'd0, lane_en}, 32'd0);
        @(negedge clk);
        chk("gap_back_to_idle", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Stall abort from requester 3.
        abort_exp_q.push_back(3);
        send_beat(3, 16'h7788, 1'b0, 1'b1);
        n0 = n_abort;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk); #1;
            if (n_abort != n0) break;
        end
        chk("abort_seen", n_abort - n0, 32'd1);
        chk("abort_latency", abort_cyc - acc_cyc, 32'd9);
        chk("abort_hold_data", {16'd0, lane_rise, lane_fall}, 32'h8877);
        chk("abort_lane_en", {31'd0, lane_en}, 32'd0);
        wait_idle("abort_idle");

        // Round-robin: all four hold single-beat packets; expect 0,1,2,3,0.
        eop_q.delete();
        for (int i = 0; i < 4; i++) begin
            lo = 8'h30 + 8'(i);
            hi = 8'hC0 + 8'(i);
            req_data[i*16 +: 16] = {hi, lo};
        end
        for (int i = 0; i < 5; i++) begin
            lo = 8'h30 + 8'(i % 4);
            hi = 8'hC0 + 8'(i % 4);
            exp_q.push_back({2'(i % 4), lo, hi, 1'b1, 1'b1});
        end
        req_last  = 4'hF;
        req_valid = 4'hF;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk); #1;
            if (eop_q.size() >= 5) break;
        end
        req_valid = '0;
        req_last  = '0;
        chk("rr_eop_count", eop_q.size(), 32'd5);
        if (eop_q.size() >= 5) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("rr_eop_spacing_%0d", k), eop_q[k+1] - eop_q[k], 32'd4);
            end
        end
        wait_idle("rr_idle");

        // Watchdog boundary: 7 empty cycles then a last beat must not abort.
        n0 = n_abort;
        send_beat(0, 16'hA1B2, 1'b0, 1'b1);
        repeat (7) @(posedge clk);
        #1;
        send_beat(0, 16'hC3D4, 1'b1, 1'b0);
        wait_idle("boundary_idle");
        chk("boundary_no_abort", n_abort - n0, 32'd0);

        // Backpressure: owner valid toggles every cycle over four beats.
        bp_data[0] = 16'h0102;
        bp_data[1] = 16'h0304;
        bp_data[2] = 16'h0506;
        bp_data[3] = 16'h0708;
        for (int k = 0; k < 4; k++) begin
            send_beat(2, bp_data[k], (k == 3), (k == 0));
            if (k < 3) begin
                @(negedge clk);
                chk("bp_nonowner_ready", {28'd0, req_ready & 4'b1011}, 32'd0);
                chk("bp_owner_ready", {31'd0, req_ready[2]}, 32'd1);
                @(posedge clk); #1;
                chk("bp_gap_en", {31'd0, lane_en}, 32'd0);
                chk("bp_hold", {16'd0, lane_rise, lane_fall}, {16'd0, bp_data[k][7:0], bp_data[k][15:8]});
            end
        end
        wait_idle("bp_idle");

        // Reset mid-packet from requester 2.
        n0 = n_abort;
        send_beat(2, 16'hEEFF, 1'b0, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("reset_mid_outputs_1");
        @(posedge clk); #1;
        chk_all_zero("reset_mid_outputs_2");
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("reset_no_abort", n_abort - n0, 32'd0);
        chk("reset_still_idle", {31'd0, busy}, 32'd0);

        // After reset the search starts at 0, so requester 1 beats requester 3.
        req_data[1*16 +: 16] = 16'h9A9B;
        req_data[3*16 +: 16] = 16'h5152;
        req_last  = 4'b1010;
        req_valid = 4'b1010;
        @(posedge clk); #1;
        chk("post_reset_grant", {30'd0, lane_owner}, 32'd1);
        chk("post_reset_ready", {28'd0, req_ready}, 32'h2);
        if (lane_owner == 2'd1) exp_q.push_back({2'd1, 8'h9B, 8'h9A, 1'b1, 1'b1});
        else abort_exp_q.push_back(int'(lane_owner));
        req_valid[3] = 1'b0;
        req_last[3]  = 1'b0;
        @(posedge clk); #1;
        req_valid = '0;
        req_last  = '0;
        wait_idle("post_reset_idle");
        repeat (4) @(posedge clk);
        #1;

        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("abort_q_drained", abort_exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
